// File: rtl/mul_writeback_seq_if.sv
// Operand/result bundle between the control unit, the multiplier and the
// register-file write port.
interface mul_writeback_seq_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 3
);
  logic                 start;
  logic [WIDTH-1:0]     op_a;
  logic [WIDTH-1:0]     op_b;
  logic [AW-1:0]        dst;
  logic                 wide;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   prod;
  logic                 we3;
  logic [AW-1:0]        wa3;
  logic [WIDTH-1:0]     wd3;

  modport master (
    output start, op_a, op_b, dst, wide,
    input  busy, done, prod, we3, wa3, wd3
  );

  modport slave (
    input  start, op_a, op_b, dst, wide,
    output busy, done, prod, we3, wa3, wd3
  );
endinterface

// File: rtl/mul_writeback_seq.sv
// Iterative shift-add multiplier that writes its product straight into the
// register file (low byte to dst, optional high byte to dst+1).
module mul_writeback_seq #(
  parameter int WIDTH = 8,
  parameter int AW    = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mul_writeback_seq_if.slave   bus,
  output logic [1:0]           dbg_state_o
);
  // Handshake: start is sampled only in IDLE; busy stays high from the cycle
  // after acceptance through the last writeback cycle, and done pulses in that
  // last cycle. A start seen while busy is dropped, never queued.

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_WB_LO = 2'd2;
  localparam logic [1:0] S_WB_HI = 2'd3;
  localparam int         CW      = $clog2(WIDTH + 1);

  logic [1:0]           state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [AW-1:0]        dst_q, dst_d;
  logic                 wide_q, wide_d;
  logic [2*WIDTH:0]     p_q, p_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 we3_q, we3_d;
  logic [AW-1:0]        wa3_q, wa3_d;
  logic [WIDTH-1:0]     wd3_q, wd3_d;

  logic [WIDTH:0]       sum;
  logic [2*WIDTH:0]     p_step;
  logic [AW-1:0]        hi_addr;

  always_comb begin
    sum     = p_q[0] ? (p_q[2*WIDTH:WIDTH] + {1'b0, a_q}) : p_q[2*WIDTH:WIDTH];
    p_step  = {sum, p_q[WIDTH-1:0]} >> 1;
    hi_addr = dst_q + AW'(1);

    state_d = state_q;
    a_d     = a_q;
    dst_d   = dst_q;
    wide_d  = wide_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    // Write-port outputs are registered, so they are decoded from the state
    // being entered rather than the current one.
    busy_d  = 1'b0;
    done_d  = 1'b0;
    we3_d   = 1'b0;
    wa3_d   = '0;
    wd3_d   = '0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d     = bus.op_a;
          dst_d   = bus.dst;
          wide_d  = bus.wide;
          p_d     = {1'b0, {WIDTH{1'b0}}, bus.op_b};
          cnt_d   = '0;
          state_d = S_RUN;
          busy_d  = 1'b1;
        end
      end
      S_RUN: begin
        p_d    = p_step;
        cnt_d  = cnt_q + CW'(1);
        busy_d = 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_WB_LO;
          prod_d  = p_step[2*WIDTH-1:0];
          wa3_d   = dst_q;
          wd3_d   = p_step[WIDTH-1:0];
          we3_d   = (dst_q != '0);   // register 0 is hardwired to zero
          done_d  = !wide_q;
        end
      end
      S_WB_LO: begin
        if (wide_q) begin
          state_d = S_WB_HI;
          busy_d  = 1'b1;
          done_d  = 1'b1;
          wa3_d   = hi_addr;
          wd3_d   = prod_q[2*WIDTH-1:WIDTH];
          we3_d   = (hi_addr != '0);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WB_HI: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      dst_q   <= '0;
      wide_q  <= 1'b0;
      p_q     <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      we3_q   <= 1'b0;
      wa3_q   <= '0;
      wd3_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      dst_q   <= dst_d;
      wide_q  <= wide_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      we3_q   <= we3_d;
      wa3_q   <= wa3_d;
      wd3_q   <= wd3_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.prod    = prod_q;
  assign bus.we3     = we3_q;
  assign bus.wa3     = wa3_q;
  assign bus.wd3     = wd3_q;
  assign dbg_state_o = state_q;
endmodule

// File: tb/tb_mul_writeback_seq.sv
// Directed bench for mul_writeback_seq: per-cycle capture of the write port
// after each launch, then hand-computed checks against that capture.
module tb_mul_writeback_seq;
  localparam int WIDTH = 8;
  localparam int AW    = 3;
  localparam int MAXC  = 32;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;

  mul_writeback_seq_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

  mul_writeback_seq #(.WIDTH(WIDTH), .AW(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---- clock / reset ----
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Per-cycle capture; index = cycle number after the launching edge (edge 0).
  logic          cap_we   [MAXC];
  logic [AW-1:0] cap_wa   [MAXC];
  logic [7:0]    cap_wd   [MAXC];
  logic          cap_done [MAXC];
  logic          cap_busy [MAXC];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---- driver: launch at edge 0, drive start per mask, capture ncyc cycles ----
  task automatic launch(input logic [7:0] a, input logic [7:0] b,
                        input logic [AW-1:0] d, input logic w,
                        input int ncyc, input logic [MAXC-1:0] start_mask);
    for (int i = 0; i < MAXC; i++) begin
      cap_we[i] = 1'b0; cap_wa[i] = '0; cap_wd[i] = '0;
      cap_done[i] = 1'b0; cap_busy[i] = 1'b0;
    end
    bus.op_a  = a;
    bus.op_b  = b;
    bus.dst   = d;
    bus.wide  = w;
    bus.start = 1'b1;
    tick();
    for (int c = 1; c <= ncyc; c++) begin
      bus.start   = start_mask[c];
      cap_we[c]   = bus.we3;
      cap_wa[c]   = bus.wa3;
      cap_wd[c]   = bus.wd3;
      cap_done[c] = bus.done;
      cap_busy[c] = bus.busy;
      tick();
    end
    bus.start = 1'b0;
  endtask

  function automatic int count_we(input int lo, input int hi);
    int n = 0;
    for (int c = lo; c <= hi; c++) n += int'(cap_we[c]);
    return n;
  endfunction

  function automatic int count_done(input int lo, input int hi);
    int n = 0;
    for (int c = lo; c <= hi; c++) n += int'(cap_done[c]);
    return n;
  endfunction

  function automatic int count_busy(input int lo, input int hi);
    int n = 0;
    for (int c = lo; c <= hi; c++) n += int'(cap_busy[c]);
    return n;
  endfunction

  initial begin
    bus.start = 1'b0;
    bus.op_a  = '0;
    bus.op_b  = '0;
    bus.dst   = '0;
    bus.wide  = 1'b0;
    rst_n     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_we3",  bus.we3,  0);
    chk("reset_wa3",  bus.wa3,  0);
    chk("reset_wd3",  bus.wd3,  0);
    chk("reset_prod", bus.prod, 0);
    rst_n = 1'b1;
    tick();

    // 13 x 11 = 0x008F, dst=3, narrow
    launch(8'd13, 8'd11, 3'd3, 1'b0, 12, '0);
    chk("t1_we_count", count_we(1, 12), 1);
    chk("t1_we_c9",    cap_we[9], 1);
    chk("t1_wa_c9",    cap_wa[9], 3);
    chk("t1_wd_c9",    cap_wd[9], 8'h8F);
    chk("t1_done_c9",  cap_done[9], 1);
    chk("t1_done_cnt", count_done(1, 12), 1);
    chk("t1_busy_1_9", count_busy(1, 9), 9);
    chk("t1_busy_c10", cap_busy[10], 0);
    chk("t1_wa_c8",    cap_wa[8], 0);
    chk("t1_prod",     bus.prod, 16'h008F);

    // 255 x 255 = 0xFE01, dst=2, wide
    launch(8'd255, 8'd255, 3'd2, 1'b1, 12, '0);
    chk("t2_we_c9",    cap_we[9], 1);
    chk("t2_wa_c9",    cap_wa[9], 2);
    chk("t2_wd_c9",    cap_wd[9], 8'h01);
    chk("t2_we_c10",   cap_we[10], 1);
    chk("t2_wa_c10",   cap_wa[10], 3);
    chk("t2_wd_c10",   cap_wd[10], 8'hFE);
    chk("t2_done_c9",  cap_done[9], 0);
    chk("t2_done_c10", cap_done[10], 1);
    chk("t2_done_cnt", count_done(1, 12), 1);
    chk("t2_busy_c10", cap_busy[10], 1);
    chk("t2_busy_c11", cap_busy[11], 0);
    chk("t2_prod",     bus.prod, 16'hFE01);

    // 0x10 x 0x10 = 0x0100, dst=7, wide: high byte wraps to r0 and is suppressed
    launch(8'h10, 8'h10, 3'd7, 1'b1, 12, '0);
    chk("t3_we_c9",    cap_we[9], 1);
    chk("t3_wa_c9",    cap_wa[9], 7);
    chk("t3_wd_c9",    cap_wd[9], 8'h00);
    chk("t3_we_c10",   cap_we[10], 0);
    chk("t3_wa_c10",   cap_wa[10], 0);
    chk("t3_wd_c10",   cap_wd[10], 8'h01);
    chk("t3_done_c10", cap_done[10], 1);
    chk("t3_prod",     bus.prod, 16'h0100);

    // 0x21 x 3 = 0x0063, dst=0, narrow: no write at all
    launch(8'h21, 8'h03, 3'd0, 1'b0, 12, '0);
    chk("t4_we_count", count_we(1, 12), 0);
    chk("t4_wa_c9",    cap_wa[9], 0);
    chk("t4_wd_c9",    cap_wd[9], 8'h63);
    chk("t4_done_c9",  cap_done[9], 1);
    chk("t4_prod",     bus.prod, 16'h0063);

    // 0 x 0xA5, dst=4: latency not shortened by a zero operand
    launch(8'h00, 8'hA5, 3'd4, 1'b0, 12, '0);
    chk("t5_busy_1_9", count_busy(1, 9), 9);
    chk("t5_busy_c10", cap_busy[10], 0);
    chk("t5_we_c9",    cap_we[9], 1);
    chk("t5_wd_c9",    cap_wd[9], 8'h00);
    chk("t5_done_c9",  cap_done[9], 1);
    chk("t5_prod",     bus.prod, 16'h0000);

    // 7 x 9 = 0x3F, dst=5, extra start pulses in cycles 3 and 8 are ignored
    launch(8'd7, 8'd9, 3'd5, 1'b0, 14, 32'h0000_0108);
    chk("t6_we_count", count_we(1, 14), 1);
    chk("t6_wd_c9",    cap_wd[9], 8'h3F);
    chk("t6_done_cnt", count_done(1, 14), 1);
    chk("t6_busy_c10", cap_busy[10], 0);
    chk("t6_prod",     bus.prod, 16'h003F);

    // 6 x 7 = 0x2A, dst=6, start held through done and the idle cycle after it
    launch(8'd6, 8'd7, 3'd6, 1'b0, 22, 32'h0000_07FE);
    chk("t7_done_c9",  cap_done[9], 1);
    chk("t7_busy_c10", cap_busy[10], 0);
    chk("t7_busy_c11", cap_busy[11], 1);
    chk("t7_done_c19", cap_done[19], 1);
    chk("t7_done_cnt", count_done(1, 22), 2);
    chk("t7_we_count", count_we(1, 22), 2);
    chk("t7_wd_c19",   cap_wd[19], 8'h2A);
    chk("t7_prod",     bus.prod, 16'h002A);

    // Asynchronous reset in cycle 5 of a multiply
    bus.op_a  = 8'hFF;
    bus.op_b  = 8'hFF;
    bus.dst   = 3'd1;
    bus.wide  = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (3) tick();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_busy",  bus.busy, 0);
    chk("rst_done",  bus.done, 0);
    chk("rst_we3",   bus.we3,  0);
    chk("rst_wa3",   bus.wa3,  0);
    chk("rst_wd3",   bus.wd3,  0);
    chk("rst_prod",  bus.prod, 0);
    chk("rst_state", dbg_state, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    launch(8'd3, 8'd5, 3'd1, 1'b0, 12, '0);
    chk("t8_we_count", count_we(1, 12), 1);
    chk("t8_we_c9",    cap_we[9], 1);
    chk("t8_wa_c9",    cap_wa[9], 1);
    chk("t8_wd_c9",    cap_wd[9], 8'h0F);
    chk("t8_done_c9",  cap_done[9], 1);
    chk("t8_prod",     bus.prod, 16'h000F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the run always ends on its own.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "time limit reached");
  end
endmodule

// File: doc/mul_writeback_seq.md
# mul_writeback_seq

Iterative 8x8 unsigned shift-add multiplier that sits between the register-file read ports and its write port. It consumes the two read operands, computes a 16-bit product over several cycles and drives the register-file write port (`we3`/`wa3`/`wd3`) directly. The low byte goes to the destination register, and the high byte optionally goes to the next register. A start/busy/done handshake lets the control unit stall while a multiply is in flight.

## Interface
- `WIDTH`, 8: operand width; product is 2*WIDTH.
- `AW`, 3: register address width; register file depth is 2^AW.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `start` input 1: request a multiply; sampled only in IDLE.
- `op_a` input WIDTH: multiplicand (register-file `rd1`).
- `op_b` input WIDTH: multiplier (register-file `rd2`).
- `dst` input AW: destination register for the low byte.
- `wide` input 1: 1 = also write the high byte to `(dst+1) mod 2^AW`.
- `busy` output 1: high while a multiply is in progress, including writeback.
- `done` output 1: one-cycle pulse in the final writeback cycle.
- `prod` output 2*WIDTH: last completed product; held until the next completion.
- `we3` output 1: register-file write enable.
- `wa3` output AW: register-file write address.
- `wd3` output WIDTH: register-file write data.

## Operation
- States: IDLE, RUN, WB_LO, WB_HI.
- **IDLE**
  - `busy`=0.
  - `start`=1 latches `op_a`, `op_b`, `dst` and `wide`, loads `P = {0, zeros(WIDTH), op_b}` (2*WIDTH+1 bits), clears the iteration counter and moves to RUN.
  - `start`=0 stays in IDLE.
- **RUN**, once per cycle:
  - If `P[0]`=1, then `P[2W:W] += A`, where A is the latched `op_a` and the sum is WIDTH+1 bits, with carry kept in `P[2W]`.
  - Then shift P right by 1.
  - Increment the counter; after exactly WIDTH iterations go to WB_LO.
  - The product is `P[2W-1:0]`, exact and with no overflow.
- **WB_LO**
  - `prod` is updated with the final product on entry.
  - `wa3`=dst, `wd3`=prod[WIDTH-1:0], `we3`=1 unless dst==0.
  - Next state is WB_HI if `wide`=1; otherwise IDLE with `done`=1 in this cycle.
- **WB_HI**
  - `wa3`=(dst+1) mod 2^AW, `wd3`=prod[2W-1:W], `we3`=1 unless that address is 0.
  - `done`=1; next state IDLE.
- Writes to register 0 are suppressed: `we3` is held 0, while `wa3`/`wd3` still show the values. This protects the hardwired-zero register. `done` is still issued.
- `start` while `busy`=1 is ignored; it is not queued.
- `we3`, `wa3`, `wd3`, `busy` and `done` are registered outputs decoded from state registers. They are stable for the whole cycle and are sampled by the register file at the closing rising edge.
- Outside the WB states: `we3`=0, `wa3`=0, `wd3`=0.
- **Reset** (`rst_n`=0, any time, asynchronous):
  - State returns to IDLE.
  - `busy`, `done`, `we3`, `wa3`, `wd3`, `prod`, P and the counter are all cleared to 0.
  - A multiply aborted mid-RUN or mid-WB produces no further writes.
  - After deassertion the first `start` is accepted on the first rising edge.

## Timing
- Edge 0: `start` sampled in IDLE.
- Cycles 1..WIDTH (1..8): RUN, `busy`=1.
- Cycle WIDTH+1 (9): WB_LO, low-byte write committed at its closing edge.
- Cycle WIDTH+2 (10), only if `wide`=1: WB_HI.
- Latency from `start` to `done`: 9 cycles (narrow) or 10 (wide). Fixed and data-independent; zero operands do not shorten it.
- The next `start` is accepted in the cycle after `done`, giving a back-to-back throughput of one multiply per 10 or 11 cycles.
- `prod` changes only at the edge entering WB_LO.

## Test plan
- 13 × 11 (0x0D × 0x0B), dst=3, wide=0:
  - `we3`=1 for exactly one cycle, in cycle 9, with `wa3`=3 and `wd3`=0x8F.
  - `prod`=0x008F and `done` pulses in cycle 9.
- 255 × 255, dst=2, wide=1:
  - Cycle 9: wa3=2, wd3=0x01.
  - Cycle 10: wa3=3, wd3=0xFE.
  - `prod`=0xFE01; `done` only in cycle 10.
- Address edge cases:
  - dst=7, wide=1, 0x10 × 0x10: r7 gets 0x00 in cycle 9; cycle 10 has wa3=0 with `we3`=0; `done`=1.
  - dst=0, wide=0: `we3` never asserted; `prod` still correct.
- Operand 0 × 0xA5: `busy` is high for the full 9 cycles and `wd3`=0x00.
- `start` pulsed again in cycles 3 and 8: ignored, and the original result is unchanged. `start` held high through `done` launches exactly one new multiply, in the cycle after `done`.
- `rst_n` asserted asynchronously in cycle 5 of a multiply:
  - All outputs are 0 immediately and no write occurs.
  - After release, 3 × 5 with dst=1 writes 0x0F at cycle 9.
